// File: rtl/dwtden_ctrl_if.sv
// rtl/dwtden_ctrl_if.sv - control/threshold bus between a host and the denoiser run controller
interface dwtden_ctrl_if;
   logic               start;
   logic               stop;
   logic               wr_en;
   logic        [1:0]  wr_addr;
   logic signed [15:0] wr_data;
   logic               ena1;
   logic               ena2;
   logic               ena3;
   logic        [2:0]  phase;
   logic signed [15:0] t4d1;
   logic signed [15:0] t4d2;
   logic signed [15:0] t4d3;
   logic signed [15:0] t4a3;
   logic               cfg_pending;
   logic               busy;
   logic               y_valid;

   modport master (
      output start, stop, wr_en, wr_addr, wr_data,
      input  ena1, ena2, ena3, phase, t4d1, t4d2, t4d3, t4a3, cfg_pending, busy, y_valid
   );

   modport slave (
      input  start, stop, wr_en, wr_addr, wr_data,
      output ena1, ena2, ena3, phase, t4d1, t4d2, t4d3, t4a3, cfg_pending, busy, y_valid
   );
endinterface

// File: rtl/dwtden_ctrl.sv
// rtl/dwtden_ctrl.sv - run controller, 8-phase enable schedule and shadowed thresholds for the Haar denoiser
module dwtden_ctrl #(
   parameter int                 FILL_LAT = 48,
   parameter logic signed [15:0] THR_RST  = 16'sd0
) (
   input  logic         clk,
   input  logic         reset,
   dwtden_ctrl_if.slave bus
);

   localparam int FW = $clog2(FILL_LAT + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic        [2:0]  r_phase;
   logic               r_ena1;
   logic               r_ena2;
   logic               r_ena3;
   logic     [FW-1:0]  r_fill;
   logic signed [15:0] r_pend [4];
   logic signed [15:0] r_act  [4];
   logic               r_cfg_pending;
   logic               w_busy;
   logic               w_commit;

   assign w_busy   = (r_state != IDLE);
   assign w_commit = w_busy && (r_phase == 3'd7);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (bus.start)         w_next = RUN;
         RUN:      if (bus.stop)          w_next = STOPPING;
         STOPPING: if (r_phase == 3'd7)   w_next = IDLE;
         default:                         w_next = IDLE;
      endcase
   end

   // Enables decode the current phase one cycle late, so a pulse from phase 7 still leaves on the first IDLE cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase <= 3'd0;
         r_ena1  <= 1'b0;
         r_ena2  <= 1'b0;
         r_ena3  <= 1'b0;
         r_fill  <= '0;
      end else if (!w_busy) begin
         r_phase <= 3'd0;
         r_ena1  <= 1'b0;
         r_ena2  <= 1'b0;
         r_ena3  <= 1'b0;
         if (bus.start) r_fill <= '0;
      end else begin
         r_phase <= r_phase + 3'd1;
         r_ena1  <= r_phase[0];
         r_ena2  <= (r_phase[1:0] == 2'b01);
         r_ena3  <= (r_phase == 3'd5);
         if (r_fill != FW'(FILL_LAT)) r_fill <= r_fill + FW'(1);
      end
   end

   // The write is applied after the commit so a write on the boundary edge stays pending for the next frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            r_pend[i] <= THR_RST;
            r_act[i]  <= THR_RST;
         end
         r_cfg_pending <= 1'b0;
      end else begin
         if (w_commit) begin
            for (int i = 0; i < 4; i++) r_act[i] <= r_pend[i];
            r_cfg_pending <= 1'b0;
         end
         if (bus.wr_en) begin
            r_pend[bus.wr_addr] <= bus.wr_data;
            if (!w_busy) r_act[bus.wr_addr] <= bus.wr_data;
            else         r_cfg_pending      <= 1'b1;
         end
      end
   end

   assign bus.ena1        = r_ena1;
   assign bus.ena2        = r_ena2;
   assign bus.ena3        = r_ena3;
   assign bus.phase       = r_phase;
   assign bus.t4d1        = r_act[0];
   assign bus.t4d2        = r_act[1];
   assign bus.t4d3        = r_act[2];
   assign bus.t4a3        = r_act[3];
   assign bus.cfg_pending = r_cfg_pending;
   assign bus.busy        = w_busy;
   assign bus.y_valid     = w_busy && (r_fill >= FW'(FILL_LAT - 1));

endmodule

// File: doc/dwtden_ctrl.md
Name: dwtden_ctrl

Overview:
- Run controller and threshold configuration block for the 3-level Haar denoiser datapath.
- Generates the 8-phase sample schedule: clock enables ena1/ena2/ena3 and the frame phase counter.
- Holds the four threshold registers behind a shadow/commit scheme, so thresholds only change on a frame boundary.
- Flags when the synthesis output y is valid after pipeline fill.

Parameters:
FILL_LAT, 48, RUN cycles from start acceptance until y_valid rises (covers the D1 delay line plus synthesis pipeline).
THR_RST, 16'sd0, reset value of all pending and active thresholds.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  pulse; begin RUN (ignored unless IDLE)
stop  in  1  pulse; request end of RUN at next frame boundary
wr_en  in  1  threshold write strobe
wr_addr  in  2  0=t4d1, 1=t4d2, 2=t4d3, 3=t4a3
wr_data  in  16  signed threshold value
ena1, ena2, ena3  out  1  level 1/2/3 clock enables to the datapath
phase  out  3  frame phase counter (count)
t4d1, t4d2, t4d3, t4a3  out  16  active thresholds (signed)
cfg_pending  out  1  a written value awaits commit
busy  out  1  state != IDLE
y_valid  out  1  datapath output is meaningful

Behaviour:
- States: IDLE, RUN, STOPPING. Reset -> IDLE.
- Reset values: phase=0, ena*=0, busy=0, y_valid=0, cfg_pending=0, all thresholds=THR_RST, fill counter=0.
- IDLE:
  - phase held 0, ena*=0.
  - start -> RUN next cycle; fill counter cleared.
- RUN and STOPPING:
  - phase increments each cycle, wraps 7->0.
  - Enables are registered and decode the current phase, so each is high the cycle after the listed phase:
    - ena1 after phase 1, 3, 5, 7.
    - ena2 after phase 1, 5.
    - ena3 after phase 5.
  - Result: ena1 is 4 cycles in 8, ena2 is 2 in 8, ena3 is 1 in 8. First ena1 pulse occurs 2 cycles after entering RUN.
- stop in RUN -> STOPPING. stop in STOPPING or IDLE is ignored.
- STOPPING:
  - Continues until the cycle with phase==7, then -> IDLE.
  - Phase lands at 0. The ena pulse registered from phase 7 still issues in the first IDLE cycle; then ena*=0.
- start and stop in the same RUN cycle: stop wins. start while RUN or STOPPING is ignored.
- Fill counter:
  - Saturating; counts RUN/STOPPING cycles.
  - y_valid=1 once the counter reaches FILL_LAT, i.e. at the FILL_LAT-th cycle after entering RUN.
  - y_valid clears on entry to IDLE.
- Thresholds:
  - wr_en writes the pending[wr_addr] register and sets cfg_pending.
  - In IDLE, a write also updates the matching active register in the same edge; cfg_pending stays 0.
  - In RUN/STOPPING, commit (active<=pending for all four, cfg_pending<=0) happens on the edge where phase==7 (frame boundary).
  - Write on the commit edge: the commit uses pending values from before the write. The new value lands in pending, cfg_pending=1, and it commits at the next boundary.
  - Negative wr_data is stored as-is (no clamping).
- Reset asserted mid-RUN: immediate return to reset values. Pending writes are lost.

Test Plan:
- Reset, start at cycle 0 -> busy=1 next cycle; ena1 high exactly after phases 1,3,5,7; ena2 after 1,5; ena3 after 5 only; 32 cycles give 16/8/4 pulses.
- FILL_LAT=48, start -> y_valid low for 47 RUN cycles, high from cycle 48; stop then IDLE -> y_valid=0.
- In IDLE, write addr 2 = 16'sd300 -> t4d3=300 next cycle, cfg_pending stays 0.
- In RUN, write addr 0 = 16'sd120 at phase 2 -> cfg_pending=1, t4d1 unchanged until the phase-7 edge, then t4d1=120, cfg_pending=0.
- Write addr 3 = -16'sd5 on the phase-7 edge -> previous pending commits; t4a3 becomes -5 only at the next phase-7 edge.
- stop at phase 3 -> phase runs 4..7, IDLE with phase=0, one trailing ena1 pulse (from phase 7), then all ena=0. Assert reset at phase 4 of a later RUN -> all outputs at reset values immediately.
